router_credit_ctrl: RTL and testbench

- Per-output-port credit tracker for the 5-port (N,S,E,W,L) mesh router.
- Sits beside the router arbiter:
  - consumes the arbiter's per-output decrement pulses (one flit sent downstream);
  - consumes credit-return pulses from the downstream neighbours;
  - drives the arbiter's per-port credit-available inputs.
- Controls router start-up, clear and error lockout via a small state machine.

---
 rtl/router_pkg.sv | 20 ++
 rtl/credit_counter.sv | 45 ++++
 rtl/router_credit_ctrl.sv | 75 +++++++
 tb/tb_router_credit_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants: port indices, credit depth, credit FSM states.
// Imported by the credit controller, the input FIFOs and the arbiter.
package router_pkg;

  localparam int PORT_N    = 0;
  localparam int PORT_S    = 1;
  localparam int PORT_E    = 2;
  localparam int PORT_W    = 3;
  localparam int PORT_L    = 4;
  localparam int NUM_PORTS = 5;

  localparam int DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } cc_state_t;

endpackage

// File: rtl/credit_counter.sv
// One output port's credit counter: saturating up/down count with
// overflow/underflow detection; offending updates are dropped.
module credit_counter #(
  parameter int DEPTH = router_pkg::DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec,
  input  logic          ret,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          avail,
  output logic          ovf,
  output logic          unf
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic dn;
  logic up;

  // a simultaneous send and return cancel out, even at the limits
  assign dn = en & dec & ~ret;
  assign up = en & ret & ~dec;

  assign unf   = dn & (count == '0);
  assign ovf   = up & (count == FULL);
  assign avail = en & (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= FULL;
    end else if (clr) begin
      count <= FULL;
    end else if (dn && !unf) begin
      count <= count - ONE;
    end else if (up && !ovf) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/router_credit_ctrl.sv
// Per-output-port credit tracker for the 5-port mesh router, with
// start-up / clear / error-lockout FSM and sticky error flags.
module router_credit_ctrl
  import router_pkg::*;
#(
  parameter int DEPTH = router_pkg::DEPTH,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [NUM_PORTS-1:0]   dec_i,
  input  logic [NUM_PORTS-1:0]   ret_i,
  output logic [NUM_PORTS-1:0]   credit_o,
  output logic [NUM_PORTS*CW-1:0] count_o,
  output logic [1:0]             state_o,
  output logic                   err_o,
  output logic [NUM_PORTS-1:0]   err_port_o
);

  cc_state_t            state;
  logic                 run;
  logic [NUM_PORTS-1:0] ovf;
  logic [NUM_PORTS-1:0] unf;
  logic [NUM_PORTS-1:0] hit;

  assign run     = (state == RUN);
  assign hit     = ovf | unf;
  assign state_o = state;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    credit_counter #(
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .dec   (dec_i[p]),
      .ret   (ret_i[p]),
      .en    (run),
      .clr   (clr_i),
      .count (count_o[p*CW +: CW]),
      .avail (credit_o[p]),
      .ovf   (ovf[p]),
      .unf   (unf[p])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      err_o      <= 1'b0;
      err_port_o <= '0;
    end else if (clr_i) begin
      state      <= IDLE;
      err_o      <= 1'b0;
      err_port_o <= '0;
    end else begin
      unique case (state)
        IDLE: if (en_i) state <= RUN;
        RUN: begin
          if (|hit) begin
            state      <= ERR;
            err_o      <= 1'b1;
            err_port_o <= err_port_o | hit;
          end
        end
        ERR: state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_credit_ctrl.sv
// Self-checking bench for router_credit_ctrl: behavioural model feeds a
// scoreboard queue; each scenario task pops and compares inline.
module tb_router_credit_ctrl;

  localparam int D  = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [1:0]    st;
    logic          err;
    logic [4:0]    ep;
    logic [4:0]    cr;
    logic [5*CW-1:0] cnt;
  } obs_t;

  localparam logic [5*CW-1:0] ALL4 = {5{3'd4}};

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            en_i = 1'b0;
  logic            clr_i = 1'b0;
  logic [4:0]      dec_i = '0;
  logic [4:0]      ret_i = '0;
  logic [4:0]      credit_o;
  logic [5*CW-1:0] count_o;
  logic [1:0]      state_o;
  logic            err_o;
  logic [4:0]      err_port_o;

  int errors = 0;
  int checks = 0;

  int         m_cnt [5];
  logic [1:0] m_st;
  logic       m_err;
  logic [4:0] m_ep;
  obs_t       sb [$];
  obs_t       exp_o;
  obs_t       act_o;

  router_credit_ctrl #(.DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .dec_i      (dec_i),
    .ret_i      (ret_i),
    .credit_o   (credit_o),
    .count_o    (count_o),
    .state_o    (state_o),
    .err_o      (err_o),
    .err_port_o (err_port_o)
  );

  always #5 clk = ~clk;

  function automatic obs_t get_obs();
    return '{st: state_o, err: err_o, ep: err_port_o,
             cr: credit_o, cnt: count_o};
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.st  = m_st;
    o.err = m_err;
    o.ep  = m_ep;
    for (int p = 0; p < 5; p++) begin
      o.cnt[p*CW +: CW] = CW'(m_cnt[p]);
      o.cr[p] = (m_st == 2'd1) && (m_cnt[p] != 0);
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 5; p++) m_cnt[p] = D;
    m_st  = 2'd0;
    m_err = 1'b0;
    m_ep  = '0;
  endtask

  task automatic model_step(input logic en, input logic clr,
                            input logic [4:0] dec, input logic [4:0] ret);
    logic [4:0] e;
    e = '0;
    if (clr) begin
      model_reset();
    end else if (m_st == 2'd0) begin
      if (en) m_st = 2'd1;
    end else if (m_st == 2'd1) begin
      for (int p = 0; p < 5; p++) begin
        if (dec[p] && !ret[p]) begin
          if (m_cnt[p] == 0) e[p] = 1'b1;
          else m_cnt[p] = m_cnt[p] - 1;
        end else if (ret[p] && !dec[p]) begin
          if (m_cnt[p] == D) e[p] = 1'b1;
          else m_cnt[p] = m_cnt[p] + 1;
        end
      end
      if (e != 0) begin
        m_st  = 2'd2;
        m_err = 1'b1;
        m_ep  = m_ep | e;
      end
    end
  endtask

  task automatic drive(input logic en, input logic clr,
                       input logic [4:0] dec, input logic [4:0] ret);
    en_i  = en;
    clr_i = clr;
    dec_i = dec;
    ret_i = ret;
    model_step(en, clr, dec, ret);
    sb.push_back(model_obs());
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input string name);
    exp_o = sb.pop_front();
    act_o = get_obs();
    checks++;
    if (act_o !== exp_o) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act_o, exp_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (get_obs() !== obs_t'({2'd0, 1'b0, 5'd0, 5'd0, ALL4})) begin
      errors++;
      $display("FAIL reset: got %h want %h", get_obs(),
               obs_t'({2'd0, 1'b0, 5'd0, 5'd0, ALL4}));
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_enable();
    drive(1'b0, 1'b0, 5'h1f, 5'h00);
    pop_cmp("idle_ignore");
    drive(1'b1, 1'b0, 5'h00, 5'h00);
    pop_cmp("enable");
    checks++;
    if (state_o !== 2'd1 || credit_o !== 5'h1f || count_o !== ALL4) begin
      errors++;
      $display("FAIL enable_run: got st=%0d cr=%b cnt=%h want 1 11111 %h",
               state_o, credit_o, count_o, ALL4);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 5'b00001, 5'b00000);
      pop_cmp("drain");
    end
    checks++;
    if (count_o[2:0] !== 3'd0 || credit_o !== 5'b11110 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: got n=%0d cr=%b err=%b want 0 11110 0",
               count_o[2:0], credit_o, err_o);
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'b00001, 5'b00001);
      pop_cmp("simul_zero");
    end
    drive(1'b0, 1'b0, 5'b00000, 5'b00001);
    pop_cmp("return_one");
    checks++;
    if (count_o[2:0] !== 3'd1 || credit_o[0] !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL return_one_val: got n=%0d cr0=%b err=%b want 1 1 0",
               count_o[2:0], credit_o[0], err_o);
    end
  endtask

  task automatic test_overflow();
    drive(1'b0, 1'b0, 5'b00000, 5'b00100);
    pop_cmp("overflow");
    checks++;
    if (err_o !== 1'b1 || err_port_o !== 5'b00100 || state_o !== 2'd2 ||
        credit_o !== 5'd0 || count_o[8:6] !== 3'd4) begin
      errors++;
      $display("FAIL overflow_val: got e=%b ep=%b st=%0d cr=%b E=%0d",
               err_o, err_port_o, state_o, credit_o, count_o[8:6]);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 5'h1f, 5'h00);
      pop_cmp("err_frozen");
    end
    checks++;
    if (count_o !== {3'd4, 3'd4, 3'd4, 3'd4, 3'd1} || state_o !== 2'd2) begin
      errors++;
      $display("FAIL frozen_val: got cnt=%h st=%0d want %h 2",
               count_o, state_o, {3'd4, 3'd4, 3'd4, 3'd4, 3'd1});
    end
  endtask

  task automatic test_clear();
    drive(1'b1, 1'b1, 5'h00, 5'h00);
    pop_cmp("clear");
    checks++;
    if (state_o !== 2'd0 || err_o !== 1'b0 || err_port_o !== 5'd0 ||
        count_o !== ALL4 || credit_o !== 5'd0) begin
      errors++;
      $display("FAIL clear_val: got st=%0d e=%b ep=%b cnt=%h",
               state_o, err_o, err_port_o, count_o);
    end
    drive(1'b1, 1'b0, 5'h00, 5'h00);
    pop_cmp("reenable");
    checks++;
    if (state_o !== 2'd1) begin
      errors++;
      $display("FAIL reenable_st: got %0d want 1", state_o);
    end
  endtask

  task automatic test_multi_err();
    drive(1'b0, 1'b0, 5'b00000, 5'b11000);
    pop_cmp("multi_err");
    checks++;
    if (err_port_o !== 5'b11000 || state_o !== 2'd2) begin
      errors++;
      $display("FAIL multi_err_val: got ep=%b st=%0d want 11000 2",
               err_port_o, state_o);
    end
    drive(1'b0, 1'b1, 5'h00, 5'h00);
    pop_cmp("multi_clr");
    drive(1'b1, 1'b0, 5'h00, 5'h00);
    pop_cmp("multi_en");
  endtask

  task automatic test_back_to_back();
    logic [4:0] d;
    logic [4:0] r;
    for (int i = 0; i < 40; i++) begin
      d = 5'($urandom) & 5'($urandom);
      r = 5'($urandom) & 5'($urandom) & 5'($urandom);
      drive(1'b0, 1'b0, d, r);
      pop_cmp("b2b");
      if (m_st == 2'd2) begin
        drive(1'b0, 1'b1, 5'h00, 5'h00);
        pop_cmp("b2b_clr");
        drive(1'b1, 1'b0, 5'h00, 5'h00);
        pop_cmp("b2b_en");
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 5'h1f, 5'h00);
      pop_cmp("pre_reset");
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (get_obs() !== obs_t'({2'd0, 1'b0, 5'd0, 5'd0, ALL4})) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", get_obs(),
               obs_t'({2'd0, 1'b0, 5'd0, 5'd0, ALL4}));
    end
    en_i  = 1'b0;
    dec_i = '0;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 5'h00, 5'h00);
    pop_cmp("post_reset_en");
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_enable();
    test_drain();
    test_simul();
    test_overflow();
    test_clear();
    test_multi_err();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
